// File: rtl/skyhop_map_pkg.sv
// Shared types and helpers for the streaming map-layer generator.
// Column masks are returned LSB-aligned with column 0 at bit (cols-1).
package skyhop_map_pkg;

  localparam int unsigned MAX_COLS   = 32;
  localparam int unsigned MAX_LFSR_W = 64;

  // Gray-coded so every legal transition flips a single bit
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_READY = 2'b11,
    S_EXTRA = 2'b10
  } state_t;

  function automatic logic [MAX_COLS-1:0] single_col(input int unsigned cols,
                                                      input int unsigned col);
    return MAX_COLS'(1) << (cols - 1 - col);
  endfunction

  function automatic logic [MAX_COLS-1:0] parity_mask(input int unsigned cols,
                                                       input logic parity);
    logic [MAX_COLS-1:0] m;
    m = '0;
    for (int unsigned c = 0; c < MAX_COLS; c++) begin
      if (c < cols && c[0] == parity) m = m | single_col(cols, c);
    end
    return m;
  endfunction

  function automatic logic [MAX_COLS-1:0] start_layer(input int unsigned cols);
    return single_col(cols, cols / 2);
  endfunction

  // Right-shifting Galois tap masks; 16 bits is x^16+x^14+x^13+x^11+1
  function automatic logic [MAX_LFSR_W-1:0] default_taps(input int unsigned w);
    logic [MAX_LFSR_W-1:0] t;
    case (w)
      32'd8:   t = MAX_LFSR_W'(8'hB8);
      32'd16:  t = MAX_LFSR_W'(16'hB400);
      32'd24:  t = MAX_LFSR_W'(24'hE10000);
      32'd32:  t = MAX_LFSR_W'(32'hA3000000);
      default: t = MAX_LFSR_W'(1) << (w - 1);
    endcase
    return t;
  endfunction

endpackage

// File: rtl/map_lfsr.sv
// Galois LFSR random source; advances one step per cycle with step high.
module map_lfsr
  import skyhop_map_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter logic [W-1:0] SEED = W'(16'hACE1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] TAPS = W'(default_taps(W));

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else if (step) begin
      value <= (value >> 1) ^ (value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/map_layer_stream_generator.sv
// Streams a start layer plus random alternating-parity layers over valid/ready,
// then serves one extra random layer per next_layer request.
module map_layer_stream_generator
  import skyhop_map_pkg::*;
#(
  parameter int unsigned COLS        = 7,
  parameter int unsigned INIT_LAYERS = 4,
  parameter int unsigned LFSR_W      = 16,
  parameter logic [63:0] SEED        = 64'hACE1,
  parameter int unsigned IDX_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              generate_map,
  input  logic              next_layer,
  input  logic              layer_ready,
  output logic [0:COLS-1]   layer_map,
  output logic [0:COLS-1]   block_type,
  output logic              layer_valid,
  output logic [IDX_W-1:0]  layer_idx,
  output logic              map_ready
);

  localparam int unsigned CNT_W = (INIT_LAYERS > 1) ? $clog2(INIT_LAYERS) : 1;
  localparam logic [CNT_W-1:0] REM_INIT = CNT_W'(INIT_LAYERS - 1);
  localparam logic [COLS-1:0] START     = COLS'(start_layer(COLS));
  localparam logic [LFSR_W-1:0] SEED_W  = LFSR_W'(SEED);

  if (COLS < 3 || COLS > MAX_COLS) begin : g_bad_cols
    $error("COLS out of range");
  end
  if (INIT_LAYERS < 1) begin : g_bad_init
    $error("INIT_LAYERS must be at least 1");
  end
  if (LFSR_W < 2 * COLS || LFSR_W > MAX_LFSR_W) begin : g_bad_lfsr_w
    $error("LFSR_W must be at least 2*COLS");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("SEED must be nonzero");
  end

  state_t            state, state_d;
  logic              parity, parity_d;
  logic [CNT_W-1:0]  rem, rem_d;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_step_c;
  logic              accept_c;

  logic [COLS-1:0]   map_d, block_d;
  logic              valid_d, map_ready_d;
  logic [IDX_W-1:0]  idx_d;

  logic [COLS-1:0]   lo_c, hi_c, mask_c, raw_c, rnd_map_c, rnd_block_c;

  map_lfsr #(
    .W    (LFSR_W),
    .SEED (SEED_W)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step_c),
    .value (lfsr)
  );

  // Random layer shaping; bit COLS-1 of each slice is column 0
  always_comb begin
    lo_c   = COLS'(lfsr);
    hi_c   = COLS'(lfsr >> COLS);
    mask_c = COLS'(parity_mask(COLS, parity));
    raw_c  = lo_c & mask_c;
    if (raw_c == '0) raw_c = COLS'(single_col(COLS, 32'(parity)));
    rnd_map_c   = raw_c;
    rnd_block_c = hi_c & raw_c;
  end

  assign accept_c = layer_valid & layer_ready;

  always_comb begin
    state_d     = state;
    parity_d    = parity;
    rem_d       = rem;
    map_d       = layer_map;
    block_d     = block_type;
    valid_d     = layer_valid;
    idx_d       = layer_idx;
    map_ready_d = map_ready;
    lfsr_step_c = 1'b0;

    case (state)
      S_IDLE: begin
        if (generate_map) begin
          map_d       = START;
          block_d     = '0;
          valid_d     = 1'b1;
          idx_d       = '0;
          rem_d       = REM_INIT;
          parity_d    = 1'b0;
          map_ready_d = 1'b0;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        if (accept_c) begin
          idx_d = layer_idx + IDX_W'(1);
          if (rem != '0) begin
            map_d       = rnd_map_c;
            block_d     = rnd_block_c;
            parity_d    = ~parity;
            lfsr_step_c = 1'b1;
            rem_d       = rem - CNT_W'(1);
          end else begin
            valid_d     = 1'b0;
            map_ready_d = 1'b1;
            state_d     = S_READY;
          end
        end
      end
      S_READY: begin
        // A restart takes priority over a scroll request
        if (generate_map) begin
          map_d       = START;
          block_d     = '0;
          valid_d     = 1'b1;
          idx_d       = '0;
          rem_d       = REM_INIT;
          parity_d    = 1'b0;
          map_ready_d = 1'b0;
          state_d     = S_FILL;
        end else if (next_layer) begin
          map_d       = rnd_map_c;
          block_d     = rnd_block_c;
          parity_d    = ~parity;
          lfsr_step_c = 1'b1;
          valid_d     = 1'b1;
          state_d     = S_EXTRA;
        end
      end
      S_EXTRA: begin
        if (accept_c) begin
          idx_d   = layer_idx + IDX_W'(1);
          valid_d = 1'b0;
          state_d = S_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      parity      <= 1'b0;
      rem         <= '0;
      layer_map   <= '0;
      block_type  <= '0;
      layer_valid <= 1'b0;
      layer_idx   <= '0;
      map_ready   <= 1'b0;
    end else begin
      state       <= state_d;
      parity      <= parity_d;
      rem         <= rem_d;
      layer_map   <= map_d;
      block_type  <= block_d;
      layer_valid <= valid_d;
      layer_idx   <= idx_d;
      map_ready   <= map_ready_d;
    end
  end

endmodule

// File: tb/tb_map_layer_stream_generator.sv
// Directed bench: default-seed instance for batch/scroll/back-pressure/reset,
// and a second instance seeded so its first two random layers need zero-forcing.
module tb_map_layer_stream_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, gen, nxt, rdy;
  logic [0:6] lmap, btype;
  logic       lvalid, mrdy;
  logic [7:0] lidx;

  logic       gen2, nxt2, rdy2;
  logic [0:6] lmap2, btype2;
  logic       lvalid2, mrdy2;
  logic [7:0] lidx2;

  int n_checks = 0;
  int n_pass   = 0;

  map_layer_stream_generator dut (
    .clk(clk), .rst(rst), .generate_map(gen), .next_layer(nxt), .layer_ready(rdy),
    .layer_map(lmap), .block_type(btype), .layer_valid(lvalid),
    .layer_idx(lidx), .map_ready(mrdy)
  );

  map_layer_stream_generator #(.SEED(64'h202A)) dut_zf (
    .clk(clk), .rst(rst), .generate_map(gen2), .next_layer(nxt2), .layer_ready(rdy2),
    .layer_map(lmap2), .block_type(btype2), .layer_valid(lvalid2),
    .layer_idx(lidx2), .map_ready(mrdy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic check_layer(input string tag, input logic [6:0] m, input logic [6:0] b,
                             input logic [7:0] idx);
    check({tag, ".valid"}, 32'(lvalid), 32'd1);
    check({tag, ".map"},   32'(lmap),   32'(m));
    check({tag, ".block"}, 32'(btype),  32'(b));
    check({tag, ".idx"},   32'(lidx),   32'(idx));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; gen = 1'b0; nxt = 1'b0; rdy = 1'b1;
    gen2 = 1'b0; nxt2 = 1'b0; rdy2 = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    check("rst.valid", 32'(lvalid), 32'd0);
    check("rst.mrdy",  32'(mrdy),   32'd0);
    check("rst.map",   32'(lmap),   32'd0);
    check("rst.block", 32'(btype),  32'd0);
    check("rst.idx",   32'(lidx),   32'd0);

    // Zero-force instance: seed 0x202A, then 0x1015
    gen2 = 1'b1; cyc(); gen2 = 1'b0;
    check("zf.start", 32'(lmap2), 32'(7'b0001000));
    cyc();
    check("zf.even.map",   32'(lmap2),  32'(7'b1000000));
    check("zf.even.block", 32'(btype2), 32'(7'b1000000));
    cyc();
    check("zf.odd.map",    32'(lmap2),  32'(7'b0100000));
    check("zf.odd.block",  32'(btype2), 32'(7'b0100000));
    check("zf.odd.idx",    32'(lidx2),  32'd2);

    // Basic batch from seed 0xACE1 -> 0xE270 -> 0x7138
    gen = 1'b1; cyc(); gen = 1'b0;
    check_layer("b0", 7'b0001000, 7'b0000000, 8'd0);
    check("b0.mrdy", 32'(mrdy), 32'd0);
    cyc(); check_layer("b1", 7'b1000001, 7'b1000001, 8'd1);
    cyc(); check_layer("b2", 7'b0100000, 7'b0000000, 8'd2);
    cyc(); check_layer("b3", 7'b0010000, 7'b0000000, 8'd3);
    cyc();
    check("bend.valid", 32'(lvalid), 32'd0);
    check("bend.mrdy",  32'(mrdy),   32'd1);
    check("bend.idx",   32'(lidx),   32'd4);

    // Scrolling: LFSR 0x389C (odd), 0x1C4E (even), 0x0E27 (odd)
    nxt = 1'b1; cyc(); nxt = 1'b0;
    check_layer("x4", 7'b0001000, 7'b0000000, 8'd4);
    check("x4.mrdy", 32'(mrdy), 32'd1);
    cyc(); check("x4.done", 32'(lvalid), 32'd0);
    nxt = 1'b1; cyc(); nxt = 1'b0;
    check_layer("x5", 7'b1000100, 7'b0000000, 8'd5);
    cyc(); check("x5.done", 32'(lvalid), 32'd0);
    nxt = 1'b1; cyc(); nxt = 1'b0;
    check_layer("x6", 7'b0100010, 7'b0000000, 8'd6);
    check("x6.mrdy", 32'(mrdy), 32'd1);
    cyc();
    check("x6.done", 32'(lvalid), 32'd0);
    check("x6.idx",  32'(lidx),   32'd7);

    // generate_map beats next_layer; next_layer during fill is dropped
    gen = 1'b1; nxt = 1'b1; cyc(); gen = 1'b0;
    check_layer("pri", 7'b0001000, 7'b0000000, 8'd0);
    check("pri.mrdy", 32'(mrdy), 32'd0);
    cyc(); nxt = 1'b0;
    check("fill.idx1", 32'(lidx), 32'd1);
    cyc(); cyc(); cyc();
    check("fill.end.valid", 32'(lvalid), 32'd0);
    check("fill.end.mrdy",  32'(mrdy),   32'd1);
    cyc();
    check("noextra.valid", 32'(lvalid), 32'd0);
    check("noextra.idx",   32'(lidx),   32'd4);

    // Reset mid-batch at layer 2
    gen = 1'b1; cyc(); gen = 1'b0;
    cyc(); cyc();
    check("mid.idx",   32'(lidx),   32'd2);
    check("mid.valid", 32'(lvalid), 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("mrst.valid", 32'(lvalid), 32'd0);
    check("mrst.map",   32'(lmap),   32'd0);
    check("mrst.block", 32'(btype),  32'd0);
    check("mrst.idx",   32'(lidx),   32'd0);
    check("mrst.mrdy",  32'(mrdy),   32'd0);

    // Reseeded batch reproduces the first one, with back-pressure on layer 2
    gen = 1'b1; cyc(); gen = 1'b0;
    check_layer("r0", 7'b0001000, 7'b0000000, 8'd0);
    cyc(); check_layer("r1", 7'b1000001, 7'b1000001, 8'd1);
    cyc(); check_layer("r2", 7'b0100000, 7'b0000000, 8'd2);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_layer($sformatf("hold%0d", i), 7'b0100000, 7'b0000000, 8'd2);
    end
    rdy = 1'b1;
    cyc(); check_layer("r3", 7'b0010000, 7'b0000000, 8'd3);
    cyc();
    check("rend.valid", 32'(lvalid), 32'd0);
    check("rend.mrdy",  32'(mrdy),   32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/map_layer_stream_generator.md
Name: map_layer_stream_generator

Overview:
Parametrised, streaming successor to the fixed four-layer map generator.
- On `generate_map`, emits an initial batch of `INIT_LAYERS` layers: one fixed start layer, then pseudo-random layers with alternating column parity.
- Afterwards, emits one extra random layer per `next_layer` request so the playfield can scroll indefinitely.
- Sits between game control and the layer/block storage, and hands off each layer through a valid/ready handshake.

Parameters:
- COLS, 7, columns per layer (width of `layer_map` and `block_type`); at least 3.
- INIT_LAYERS, 4, layers in the initial batch, start layer included; at least 1.
- LFSR_W, 16, width of the random-source register; must be at least 2*COLS, elaboration error otherwise.
- SEED, 16'hACE1, reset value of the LFSR; must be nonzero, truncated or zero-extended to LFSR_W.
- IDX_W, 8, width of `layer_idx`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- generate_map  in  1  start or restart pulse; sampled only in S_IDLE and S_READY
- next_layer  in  1  request for one extra layer; sampled only in S_READY
- layer_ready  in  1  consumer accepts the current layer when high together with `layer_valid`
- layer_map  out  [0:COLS-1]  block present per column; column 0 is leftmost (MSB)
- block_type  out  [0:COLS-1]  block type per column (1 = special); always a subset of `layer_map`
- layer_valid  out  1  `layer_map`, `block_type` and `layer_idx` are valid
- layer_idx  out  IDX_W  index of the presented layer since the last start; wraps modulo 2^IDX_W
- map_ready  out  1  level; high once the initial batch has been fully accepted

Behaviour:
- All outputs are registered.
- Reset gives:
  - state = S_IDLE
  - `layer_map`, `block_type` and `layer_idx` = 0
  - `layer_valid` and `map_ready` = 0
  - LFSR = SEED, parity = 0, remaining count = 0
- States:
  - S_IDLE: waits for a start.
  - S_FILL: streams the initial batch.
  - S_READY: batch done, waits for a request.
  - S_EXTRA: presents one requested layer.
- S_IDLE with `generate_map` high at edge N: at edge N+1, `layer_valid` = 1 and the start layer is presented. Also at N+1, `layer_map` = a single 1 at column COLS/2 (integer division), `block_type` = 0, `layer_idx` = 0, remaining count = INIT_LAYERS-1, state = S_FILL.
- Handshake:
  - A layer is accepted on any edge where `layer_valid` and `layer_ready` are both high.
  - While `layer_valid` is high and `layer_ready` is low, every output holds stable.
  - After an accepted edge, `layer_idx` increments by 1.
- S_FILL acceptance with remaining count > 0: the next random layer is loaded on the same edge, so `layer_valid` stays high (back-to-back, one layer per cycle at full throughput). The remaining count then decrements.
- S_FILL acceptance with remaining count = 0: `layer_valid` drops to 0, `map_ready` rises to 1, state goes to S_READY.
- INIT_LAYERS = 1: the start layer is the whole batch.
- S_READY:
  - `generate_map` restarts exactly as from S_IDLE: on the same edge `map_ready` drops to 0, `layer_idx` returns to 0, and the LFSR is not reseeded.
  - Otherwise, `next_layer` loads one random layer, raises `layer_valid` and moves to S_EXTRA.
  - If both are high together, `generate_map` wins.
- S_EXTRA: acceptance drops `layer_valid` to 0 and returns to S_READY. `map_ready` stays 1 throughout.
- `generate_map` and `next_layer` are ignored in S_FILL and S_EXTRA; no queuing.
- Random layer generation (combinational from the current LFSR, registered on load):
  - Parity mask: parity 0 gives columns 0, 2, 4, …; parity 1 gives columns 1, 3, 5, ….
  - raw = LFSR[COLS-1:0] AND mask.
  - If raw = 0, the lowest-index column of the mask is forced to 1.
  - `layer_map` = the resulting raw value (after the forcing rule).
  - `block_type` = LFSR[2*COLS-1:COLS] AND `layer_map`.
  - Column 0 of the layer takes bit COLS-1 of the slice.
- Each load of a random layer steps a Galois LFSR by exactly one step and toggles parity. The start layer steps neither.
- Parity is cleared to 0 on every start, so the first random layer always uses the even mask.
- `rst` mid-stream returns all state and outputs to reset values on the next edge, aborting any in-flight layer.

Decomposition:
- Package `skyhop_map_pkg` holds:
  - state encodings (Gray-coded 2-bit)
  - `parity_mask(COLS, parity)` and `start_layer(COLS)` functions
  - default LFSR taps per LFSR_W (16: x^16+x^14+x^13+x^11+1)
- Sub-module `map_lfsr` (parameters W, SEED; ports `clk`, `rst`, `step`, `value[W-1:0]`): Galois LFSR that advances on `step`.
- Top module holds the FSM, counters and layer shaping.

Test Plan:
- Basic batch (COLS=7, INIT_LAYERS=4, `layer_ready` tied high): pulse `generate_map`.
  - Next cycle: `layer_map` = 0001000, `block_type` = 0000000, `layer_idx` = 0.
  - Then 3 consecutive cycles with `layer_idx` 1, 2, 3; `layer_map` within masks 1010101, 0101010, 1010101; none zero; `block_type` ⊆ `layer_map`; values match a reference LFSR model.
  - Then `layer_valid` = 0 and `map_ready` = 1.
- Back-pressure: hold `layer_ready` low for 5 cycles on layer 2 → outputs unchanged across all 5 cycles; after release, layer 3 follows one cycle later.
- Zero-force: start with a SEED whose masked slice is 0 → `layer_map` = 1000000 (even mask) or 0100000 (odd mask), with `block_type` bit valid only in that column.
- Scrolling: in S_READY, pulse `next_layer` three times → three single-layer handshakes with `layer_idx` 4, 5, 6; parity continues alternating; `map_ready` stays 1.
- Priority and ignore: `generate_map` and `next_layer` high together in S_READY → restart to the start layer with `layer_idx` = 0 and `map_ready` = 0. A `next_layer` pulse during S_FILL produces no extra layer.
- Reset mid-batch: assert `rst` while `layer_idx` = 2 and `layer_valid` = 1 → next cycle all outputs are 0; a new `generate_map` reproduces the batch from the first test exactly (LFSR back at SEED).
